// File: rtl/alu_writeback_if.sv
// alu_writeback_if: ALU/load/register-file bus; define ALU_WB_LOOKUP_EN for the lookup port
interface alu_writeback_if #(
  parameter int ALU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      aluValid;
  logic                      aluReady;
  logic [ALU_WIDTH-1:0]      aluOut;
  logic [REG_ADDR_WIDTH-1:0] aluRd;
  logic                      ldValid;
  logic                      ldReady;
  logic [REG_ADDR_WIDTH-1:0] ldRd;
  logic [ALU_WIDTH-1:0]      ldDat;
  logic                      rfWe;
  logic [REG_ADDR_WIDTH-1:0] rfWaddr;
  logic [ALU_WIDTH-1:0]      rfWdat;
`ifdef ALU_WB_LOOKUP_EN
  logic [REG_ADDR_WIDTH-1:0] lookupRs;
  logic                      lookupHit;
  logic [ALU_WIDTH-1:0]      lookupDat;
`endif
  modport master (
`ifdef ALU_WB_LOOKUP_EN
    output lookupRs, input lookupHit, lookupDat,
`endif
    output aluValid, aluOut, aluRd, ldValid, ldRd, ldDat,
    input  aluReady, ldReady, rfWe, rfWaddr, rfWdat
  );
  modport slave (
`ifdef ALU_WB_LOOKUP_EN
    input lookupRs, output lookupHit, lookupDat,
`endif
    input  aluValid, aluOut, aluRd, ldValid, ldRd, ldDat,
    output aluReady, ldReady, rfWe, rfWaddr, rfWdat
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: 2-entry ALU result FIFO arbitrated with load writes onto one register-file port; ALU_WB_LOOKUP_EN adds pending-write lookup
module alu_writeback #(
  parameter int ALU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             rst_n,
  alu_writeback_if.slave  bus
);
  logic [REG_ADDR_WIDTH-1:0] r_rd0, r_rd1, w_rd0_nxt, w_rd1_nxt;
  logic [ALU_WIDTH-1:0]      r_dat0, r_dat1, w_dat0_nxt, w_dat1_nxt;
  logic [1:0]                r_count, w_count_nxt;
  logic [2:0]                r_starve, w_starve_nxt;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;
  logic [ALU_WIDTH-1:0]      r_wdat;
  logic                      w_push, w_force, w_sel_alu, w_sel_ld, w_push_head;

  assign bus.aluReady = r_count != 2'd2;
  assign w_force      = r_starve == 3'd4 && r_count != 2'd0;
  assign bus.ldReady  = !w_force;
  assign w_push       = bus.aluValid && bus.aluReady && bus.aluRd != '0;
  assign w_sel_alu    = w_force || (!bus.ldValid && r_count != 2'd0);
  assign w_sel_ld     = !w_force && bus.ldValid;
  assign w_push_head  = r_count == 2'd0 || (r_count == 2'd1 && w_sel_alu);
  assign bus.rfWe     = r_we;
  assign bus.rfWaddr  = r_waddr;
  assign bus.rfWdat   = r_wdat;

  // FIFO shift on pop, new entry lands in the first free slot after the pop
  always_comb begin
    w_rd0_nxt    = w_sel_alu ? r_rd1 : r_rd0;
    w_dat0_nxt   = w_sel_alu ? r_dat1 : r_dat0;
    w_rd1_nxt    = r_rd1;
    w_dat1_nxt   = r_dat1;
    if (w_push && w_push_head) begin
      w_rd0_nxt  = bus.aluRd;
      w_dat0_nxt = bus.aluOut;
    end else if (w_push) begin
      w_rd1_nxt  = bus.aluRd;
      w_dat1_nxt = bus.aluOut;
    end
    w_count_nxt  = r_count + 2'(w_push) - 2'(w_sel_alu);
    w_starve_nxt = (w_sel_alu || r_count == 2'd0) ? 3'd0 :
                   (w_sel_ld && r_starve != 3'd4) ? r_starve + 3'd1 : r_starve;
  end

  // FIFO, occupancy and starvation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd0    <= '0;
      r_rd1    <= '0;
      r_dat0   <= '0;
      r_dat1   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      r_rd0    <= w_rd0_nxt;
      r_rd1    <= w_rd1_nxt;
      r_dat0   <= w_dat0_nxt;
      r_dat1   <= w_dat1_nxt;
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // registered write port; x0 loads are granted but never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdat  <= '0;
    end else if (w_sel_alu) begin
      r_we    <= 1'b1;
      r_waddr <= r_rd0;
      r_wdat  <= r_dat0;
    end else if (w_sel_ld && bus.ldRd != '0) begin
      r_we    <= 1'b1;
      r_waddr <= bus.ldRd;
      r_wdat  <= bus.ldDat;
    end else begin
      r_we    <= 1'b0;
    end
  end

`ifdef ALU_WB_LOOKUP_EN
  logic w_hit_tail, w_hit_head, w_hit_out;
  // youngest pending write wins: tail, then head, then output register
  always_comb begin
    w_hit_tail    = r_count == 2'd2 && r_rd1 == bus.lookupRs;
    w_hit_head    = r_count != 2'd0 && r_rd0 == bus.lookupRs;
    w_hit_out     = r_we && r_waddr == bus.lookupRs;
    bus.lookupHit = bus.lookupRs != '0 && (w_hit_tail || w_hit_head || w_hit_out);
    bus.lookupDat = w_hit_tail ? r_dat1 : w_hit_head ? r_dat0 : w_hit_out ? r_wdat : '0;
  end
`endif
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed checks of ordering, backpressure, starvation, x0, reset and lookup
module tb_alu_writeback;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_writeback_if #(.ALU_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  alu_writeback #(.ALU_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.aluValid = 0; bus.aluRd = 0; bus.aluOut = 0;
    bus.ldValid = 0; bus.ldRd = 0; bus.ldDat = 0;
`ifdef ALU_WB_LOOKUP_EN
    bus.lookupRs = 0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", bus.rfWe, 0);
    chk("rst_waddr", bus.rfWaddr, 0);
    chk("rst_wdat", bus.rfWdat, 0);
    chk("rst_aluready", bus.aluReady, 1);
    chk("rst_ldready", bus.ldReady, 1);
`ifdef ALU_WB_LOOKUP_EN
    chk("rst_lookuphit", bus.lookupHit, 0);
`endif
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_aluready", bus.aluReady, 1);
    chk("post_rst_we", bus.rfWe, 0);

    // single result, one cycle latency, one pulse
    bus.aluValid = 1; bus.aluRd = 5; bus.aluOut = 32'h1234;
    tick;
    bus.aluValid = 0;
    chk("single_no_passthru", bus.rfWe, 0);
    tick;
    chk("single_we", bus.rfWe, 1);
    chk("single_waddr", bus.rfWaddr, 5);
    chk("single_wdat", bus.rfWdat, 32'h1234);
    tick;
    chk("single_one_pulse", bus.rfWe, 0);

    // full FIFO with loads held
    bus.ldValid = 1; bus.ldRd = 9; bus.ldDat = 32'h99;
    bus.aluValid = 1; bus.aluRd = 1; bus.aluOut = 32'h11;
    tick;
    chk("full_ld_first", bus.rfWaddr, 9);
    bus.aluRd = 2; bus.aluOut = 32'h22;
    tick;
    chk("full_aluready0", bus.aluReady, 0);
    bus.aluRd = 3; bus.aluOut = 32'h33;
    tick; tick; tick;
    chk("full_starve_ldready", bus.ldReady, 0);
    chk("full_still_full", bus.aluReady, 0);
    tick;
    chk("full_pop1_waddr", bus.rfWaddr, 1);
    chk("full_pop1_wdat", bus.rfWdat, 32'h11);
    chk("full_aluready1", bus.aluReady, 1);
    chk("full_ldready1", bus.ldReady, 1);
    tick;
    chk("full_ld_after", bus.rfWaddr, 9);
    bus.aluValid = 0; bus.ldValid = 0;
    tick;
    chk("full_pop2_waddr", bus.rfWaddr, 2);
    chk("full_pop2_wdat", bus.rfWdat, 32'h22);
    tick;
    chk("full_pop3_waddr", bus.rfWaddr, 3);
    chk("full_pop3_wdat", bus.rfWdat, 32'h33);
    chk("full_pop3_we", bus.rfWe, 1);
    tick;
    chk("full_drained", bus.rfWe, 0);

    // starvation override
    bus.ldValid = 1; bus.ldRd = 10; bus.ldDat = 32'hAA;
    bus.aluValid = 1; bus.aluRd = 4; bus.aluOut = 32'h44;
    tick;
    bus.aluValid = 0;
    chk("starve_ld0", bus.rfWaddr, 10);
    tick; tick; tick;
    chk("starve_ldready_s3", bus.ldReady, 1);
    chk("starve_ld3_we", bus.rfWe, 1);
    chk("starve_ld3", bus.rfWaddr, 10);
    tick;
    chk("starve_ldready_s4", bus.ldReady, 0);
    chk("starve_ld4", bus.rfWaddr, 10);
    tick;
    chk("starve_alu_waddr", bus.rfWaddr, 4);
    chk("starve_alu_wdat", bus.rfWdat, 32'h44);
    chk("starve_ldready_back", bus.ldReady, 1);
    tick;
    chk("starve_resume_waddr", bus.rfWaddr, 10);
    chk("starve_resume_wdat", bus.rfWdat, 32'hAA);
    bus.ldValid = 0;
    tick;
    chk("starve_idle", bus.rfWe, 0);

    // x0 destinations
    bus.aluValid = 1; bus.aluRd = 0; bus.aluOut = 32'hFFFF_FFFF;
    bus.ldValid = 1; bus.ldRd = 0; bus.ldDat = 32'h55;
    #1;
    chk("x0_aluready", bus.aluReady, 1);
    chk("x0_ldready", bus.ldReady, 1);
    tick;
    chk("x0_we0", bus.rfWe, 0);
    bus.aluValid = 0; bus.ldValid = 0;
    tick;
    chk("x0_we1", bus.rfWe, 0);
    chk("x0_empty", bus.aluReady, 1);

    // reset mid-operation with a full FIFO
    bus.ldValid = 1; bus.ldRd = 11; bus.ldDat = 32'hBB;
    bus.aluValid = 1; bus.aluRd = 12; bus.aluOut = 32'hC;
    tick;
    bus.aluRd = 13; bus.aluOut = 32'hD;
    tick;
    chk("rstmid_full", bus.aluReady, 0);
    bus.aluValid = 0; bus.ldValid = 0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", bus.rfWe, 0);
    chk("rstmid_aluready", bus.aluReady, 1);
    chk("rstmid_ldready", bus.ldReady, 1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rstmid_after0", bus.rfWe, 0);
    tick;
    chk("rstmid_after1", bus.rfWe, 0);
    tick;
    chk("rstmid_after2", bus.rfWe, 0);

`ifdef ALU_WB_LOOKUP_EN
    // lookup returns the youngest pending write
    bus.ldValid = 1; bus.ldRd = 9; bus.ldDat = 32'h99;
    bus.aluValid = 1; bus.aluRd = 7; bus.aluOut = 32'hA;
    tick;
    bus.aluOut = 32'hB;
    tick;
    bus.aluValid = 0;
    bus.lookupRs = 7;
    #1;
    chk("lookup7_hit", bus.lookupHit, 1);
    chk("lookup7_dat", bus.lookupDat, 32'hB);
    bus.lookupRs = 0;
    #1;
    chk("lookup0_hit", bus.lookupHit, 0);
    bus.lookupRs = 9;
    #1;
    chk("lookup9_hit", bus.lookupHit, 1);
    chk("lookup9_dat", bus.lookupDat, 32'h99);
    bus.lookupRs = 0; bus.ldValid = 0;
    tick; tick; tick;
    chk("lookup_drained", bus.rfWe, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
